// File: rtl/regfile_sb_if.sv
// Bus bundle between pipeline control and the scoreboarded register file.
// The master drives addresses and strobes; the slave returns read data and busy state.
interface regfile_sb_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
);
  logic [ADDRWIDTH-1:0]   readReg1;
  logic [ADDRWIDTH-1:0]   readReg2;
  logic [DATAWIDTH-1:0]   readData1;
  logic [DATAWIDTH-1:0]   readData2;
  logic                   busy1;
  logic                   busy2;
  logic                   write;
  logic [ADDRWIDTH-1:0]   writeReg;
  logic [DATAWIDTH-1:0]   writeData;
  logic [DATAWIDTH/8-1:0] byteEn;
  logic                   reserve;
  logic [ADDRWIDTH-1:0]   reserveReg;
  logic [ADDRWIDTH:0]     busyCount;
  logic                   conflict;

  modport master (
    output readReg1, readReg2, write, writeReg, writeData, byteEn, reserve, reserveReg,
    input  readData1, readData2, busy1, busy2, busyCount, conflict
  );

  modport slave (
    input  readReg1, readReg2, write, writeReg, writeData, byteEn, reserve, reserveReg,
    output readData1, readData2, busy1, busy2, busyCount, conflict
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with byte-enabled write, two async read ports and a per-entry busy
// scoreboard used by decode to stall on read-after-write hazards.
module regfile_sb #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH  = 1 << ADDRWIDTH;
  localparam int NBYTES = DATAWIDTH / 8;

  logic [DATAWIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]     r_busy;
  logic [ADDRWIDTH:0]   r_busyCount;
  logic                 r_conflict;

  logic                 w_wrEn;
  logic                 w_rsvEn;
  logic                 w_sameEntry;
  logic                 w_inc;
  logic                 w_dec;
  logic                 w_conflictHit;
  logic [DATAWIDTH-1:0] w_merged;
  logic [DEPTH-1:0]     w_busyNext;
  logic                 w_zero1;
  logic                 w_zero2;
  logic                 w_bypass1;
  logic                 w_bypass2;

  // Entry 0 swallows writes and reservations when it is hard-wired to zero.
  assign w_wrEn  = bus.write   && !((ZERO_REG != 0) && (bus.writeReg   == '0));
  assign w_rsvEn = bus.reserve && !((ZERO_REG != 0) && (bus.reserveReg == '0));
  assign w_sameEntry = w_wrEn && w_rsvEn && (bus.writeReg == bus.reserveReg);

  // A write is the completion event, so it releases busy; a same-cycle reserve wins.
  assign w_inc = w_rsvEn && !r_busy[bus.reserveReg];
  assign w_dec = w_wrEn && r_busy[bus.writeReg] && !w_sameEntry;
  assign w_conflictHit = w_rsvEn && r_busy[bus.reserveReg] && !w_sameEntry;

  always_comb begin
    w_merged = r_regs[bus.writeReg];
    for (int b = 0; b < NBYTES; b++) begin
      if (bus.byteEn[b]) begin
        w_merged[8*b +: 8] = bus.writeData[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_busyNext = r_busy;
    if (w_wrEn) begin
      w_busyNext[bus.writeReg] = 1'b0;
    end
    if (w_rsvEn) begin
      w_busyNext[bus.reserveReg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy      <= '0;
      r_busyCount <= '0;
      r_conflict  <= 1'b0;
    end else begin
      if (w_wrEn) begin
        r_regs[bus.writeReg] <= w_merged;
      end
      r_busy      <= w_busyNext;
      r_busyCount <= r_busyCount + (ADDRWIDTH+1)'(w_inc) - (ADDRWIDTH+1)'(w_dec);
      if (w_conflictHit) begin
        r_conflict <= 1'b1;
      end
    end
  end

  assign w_zero1   = (ZERO_REG != 0) && (bus.readReg1 == '0);
  assign w_zero2   = (ZERO_REG != 0) && (bus.readReg2 == '0);
  assign w_bypass1 = (BYPASS != 0) && w_wrEn && (bus.writeReg == bus.readReg1);
  assign w_bypass2 = (BYPASS != 0) && w_wrEn && (bus.writeReg == bus.readReg2);

  always_comb begin
    bus.readData1 = r_regs[bus.readReg1];
    bus.busy1     = r_busy[bus.readReg1];
    if (w_zero1) begin
      bus.readData1 = '0;
      bus.busy1     = 1'b0;
    end else if (w_bypass1) begin
      bus.readData1 = w_merged;
      bus.busy1     = 1'b0;
    end
  end

  always_comb begin
    bus.readData2 = r_regs[bus.readReg2];
    bus.busy2     = r_busy[bus.readReg2];
    if (w_zero2) begin
      bus.readData2 = '0;
      bus.busy2     = 1'b0;
    end else if (w_bypass2) begin
      bus.readData2 = w_merged;
      bus.busy2     = 1'b0;
    end
  end

  assign bus.busyCount = r_busyCount;
  assign bus.conflict  = r_conflict;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: dutA uses defaults (zero reg, bypass on),
// dutB has both features off and shares dutA's stimulus.
module tb_regfile_sb;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  regfile_sb_if #(.DATAWIDTH(32), .ADDRWIDTH(5)) rfA ();
  regfile_sb_if #(.DATAWIDTH(32), .ADDRWIDTH(5)) rfB ();

  regfile_sb #(.DATAWIDTH(32), .ADDRWIDTH(5), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(rfA.slave)
  );
  regfile_sb #(.DATAWIDTH(32), .ADDRWIDTH(5), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(rfB.slave)
  );

  assign rfB.readReg1   = rfA.readReg1;
  assign rfB.readReg2   = rfA.readReg2;
  assign rfB.write      = rfA.write;
  assign rfB.writeReg   = rfA.writeReg;
  assign rfB.writeData  = rfA.writeData;
  assign rfB.byteEn     = rfA.byteEn;
  assign rfB.reserve    = rfA.reserve;
  assign rfB.reserveReg = rfA.reserveReg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rd1, input logic [4:0] rd2,
                               input logic wr, input logic [4:0] wrReg, input logic [31:0] wrData,
                               input logic [3:0] be, input logic rsv, input logic [4:0] rsvReg);
    rfA.readReg1   = rd1;
    rfA.readReg2   = rd2;
    rfA.write      = wr;
    rfA.writeReg   = wrReg;
    rfA.writeData  = wrData;
    rfA.byteEn     = be;
    rfA.reserve    = rsv;
    rfA.reserveReg = rsvReg;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #2;
    checkOutput("rstBusyCount", 32'(rfA.busyCount), 32'd0);
    checkOutput("rstConflict", 32'(rfA.conflict), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full write then byte-enabled merge on entry 5.
    applyStimulus(5'd5, 5'd5, 1'b1, 5'd5, 32'h11223344, 4'hF, 1'b0, 5'd0);
    checkOutput("fullWrBypassA", rfA.readData1, 32'h11223344);
    checkOutput("fullWrNoBypassB", rfB.readData1, 32'h0);
    tick();
    applyStimulus(5'd5, 5'd5, 1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0);
    checkOutput("byteWrBypassA1", rfA.readData1, 32'h11BB33DD);
    checkOutput("byteWrBypassA2", rfA.readData2, 32'h11BB33DD);
    checkOutput("byteWrPreB", rfB.readData1, 32'h11223344);
    tick();
    applyStimulus(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("byteWrStoredA", rfA.readData1, 32'h11BB33DD);
    checkOutput("byteWrStoredB2", rfB.readData2, 32'h11BB33DD);

    // Entry 0: hard-wired in dutA, an ordinary entry in dutB.
    applyStimulus(5'd0, 5'd5, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0);
    checkOutput("zeroSameCycleA", rfA.readData1, 32'h0);
    tick();
    applyStimulus(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("zeroDataA", rfA.readData1, 32'h0);
    checkOutput("zeroBusyA", 32'(rfA.busy1), 32'd0);
    checkOutput("zeroCountA", 32'(rfA.busyCount), 32'd0);
    checkOutput("entry0DataB", rfB.readData1, 32'hFFFFFFFF);
    checkOutput("entry0BusyB", 32'(rfB.busy1), 32'd1);
    checkOutput("entry0CountB", 32'(rfB.busyCount), 32'd1);

    // Asynchronous reset mid-cycle with preloaded entries.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstDataA", rfA.readData2, 32'h0);
    checkOutput("asyncRstDataB", rfB.readData1, 32'h0);
    checkOutput("asyncRstCountB", 32'(rfB.busyCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Scoreboard: reserve 3 and 7, then complete 3.
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3);
    tick();
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7);
    tick();
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("sbCountA", 32'(rfA.busyCount), 32'd2);
    checkOutput("sbBusy3A", 32'(rfA.busy1), 32'd1);
    checkOutput("sbBusy7B", 32'(rfB.busy2), 32'd1);
    applyStimulus(5'd3, 5'd7, 1'b1, 5'd3, 32'h12345678, 4'hF, 1'b0, 5'd0);
    checkOutput("sbBypassBusyA", 32'(rfA.busy1), 32'd0);
    checkOutput("sbNoBypassBusyB", 32'(rfB.busy1), 32'd1);
    tick();
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("sbCountAfterA", 32'(rfA.busyCount), 32'd1);
    checkOutput("sbCountAfterB", 32'(rfB.busyCount), 32'd1);
    checkOutput("sbBusy3After", 32'(rfA.busy1), 32'd0);
    checkOutput("sbData3B", rfB.readData1, 32'h12345678);

    // Same-entry write and reserve while entry 9 is busy.
    applyStimulus(5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9);
    tick();
    applyStimulus(5'd7, 5'd9, 1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b1, 5'd9);
    tick();
    applyStimulus(5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("collData9", rfA.readData2, 32'hCAFEF00D);
    checkOutput("collBusy9", 32'(rfA.busy2), 32'd1);
    checkOutput("collConflict", 32'(rfA.conflict), 32'd0);
    checkOutput("collCount", 32'(rfA.busyCount), 32'd2);

    // Double reservation of entry 4 raises the sticky conflict.
    applyStimulus(5'd4, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4);
    tick();
    checkOutput("firstRsvNoConflict", 32'(rfA.conflict), 32'd0);
    tick();
    applyStimulus(5'd4, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    checkOutput("conflictSet", 32'(rfA.conflict), 32'd1);
    checkOutput("conflictCount", 32'(rfA.busyCount), 32'd3);
    applyStimulus(5'd4, 5'd9, 1'b1, 5'd4, 32'h0000ABCD, 4'b0011, 1'b0, 5'd0);
    tick();
    applyStimulus(5'd4, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    tick();
    checkOutput("conflictHeld", 32'(rfA.conflict), 32'd1);
    checkOutput("releaseCount", 32'(rfA.busyCount), 32'd2);
    checkOutput("partialWr4", rfB.readData1, 32'h0000ABCD);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("conflictCleared", 32'(rfA.conflict), 32'd0);
    checkOutput("countCleared", 32'(rfA.busyCount), 32'd0);
    checkOutput("busyCleared", 32'(rfA.busy2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with per-register scoreboard: 2^ADDRWIDTH entries of DATAWIDTH bits, two asynchronous read ports and one byte-enabled synchronous write port. Optional hard-wired zero register and write-to-read bypass. Busy bits track registers with an outstanding producer so the pipeline control can stall on read-after-write hazards. Replaces the fixed 32x32 register file in the datapath, between decode (reads, reservations) and writeback (writes, releases).

## Interface

- DATAWIDTH, 32, data width in bits; must be a multiple of 8.
- ADDRWIDTH, 5, address width; depth = 2^ADDRWIDTH.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- readReg1  in  ADDRWIDTH  read port 1 address.
- readReg2  in  ADDRWIDTH  read port 2 address.
- readData1  out  DATAWIDTH  read port 1 data (combinational).
- readData2  out  DATAWIDTH  read port 2 data (combinational).
- busy1  out  1  entry readReg1 has an outstanding producer (combinational).
- busy2  out  1  entry readReg2 has an outstanding producer (combinational).
- write  in  1  write/release strobe.
- writeReg  in  ADDRWIDTH  write address.
- writeData  in  DATAWIDTH  write data.
- byteEn  in  DATAWIDTH/8  per-byte write enable; bit i covers bits 8i+7:8i.
- reserve  in  1  mark reserveReg busy.
- reserveReg  in  ADDRWIDTH  entry to reserve.
- busyCount  out  ADDRWIDTH+1  registered number of busy entries.
- conflict  out  1  sticky: a reservation hit an already-busy entry.

## Operation

- Storage: registers[0..2^ADDRWIDTH-1], busy[0..2^ADDRWIDTH-1].
- Write: at posedge with write=1, each byte of registers[writeReg] with byteEn=1 takes writeData; other bytes hold. busy[writeReg] clears regardless of byteEn (write is the completion event).
- Reserve: at posedge with reserve=1, busy[reserveReg] sets. If it was already 1 and not cleared by a write in the same cycle, conflict sets and stays 1 until reset.
- Simultaneous write and reserve on same entry: data is written, busy ends 1 (new producer wins), conflict not set.
- ZERO_REG=1: writes, reservations to entry 0 ignored; readDataN=0 and busyN=0 when readRegN=0; entry 0 never counted.
- Read: readDataN = registers[readRegN]. BYPASS=1 and write=1 and writeReg==readRegN (and not zero entry): readDataN = merged value (writeData bytes where byteEn=1, stored bytes elsewhere), and busyN=0.
- BYPASS=0: reads show pre-write contents and current busy bit until the edge.
- busyCount: next = current + (reserve newly setting a clear bit) - (write clearing a set bit not re-reserved). Always equals popcount(busy).

## Timing

- Reset (rst_n=0, async, immediate): all registers 0, all busy 0, busyCount 0, conflict 0; readData/busy outputs follow to 0 combinationally. Reset mid-operation discards in-flight reservations; first edge after release behaves as fresh.
- Write/reserve latency: visible on reads one cycle after the edge (zero cycles via bypass when BYPASS=1).
- busyCount and conflict update at the same edge as the busy bits.
- Both read ports may address the same entry; both return identical data.
- No back-pressure; every strobe is accepted every cycle.

## Test plan

- Reset: preload entries, assert rst_n=0 mid-cycle -> all readData 0, busyCount 0, conflict 0 immediately.
- Byte write: entry 5=0x11223344, write 0xAABBCCDD byteEn=4'b0101 -> reads 0x11BB33DD next cycle; with BYPASS=1 same cycle.
- Zero register: write 0xFFFFFFFF and reserve to entry 0 -> readData 0, busy 0, busyCount unchanged.
- Scoreboard: reserve 3, 7 -> busyCount 2, busy on 3; write 3 -> busy1=0 in that cycle (bypass), busyCount 1 next cycle.
- Same-entry collision: write and reserve entry 9 simultaneously while busy -> data updated, busy[9]=1, conflict stays 0, busyCount unchanged.
- Conflict: reserve entry 4 twice on consecutive cycles without write -> conflict=1 held until rst_n low.
